// File: rtl/square_wave_pkg.sv
// Shared types and helpers for the multi-channel square/PWM generator.
package square_wave_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned MAX_WIDTH     = 16;

    // Fields are sized for the widest legal WIDTH; narrower builds zero-extend into them.
    typedef struct packed {
        logic                 en;
        logic [MAX_WIDTH-1:0] period;
        logic [MAX_WIDTH-1:0] high;
    } chan_cfg_t;

    function automatic int unsigned ch_sel_width(input int unsigned ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/square_wave_chan.sv
// One PWM channel: active/shadow config, period counter and registered wave/tick.
module square_wave_chan
    import square_wave_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_wr,
    input  chan_cfg_t i_cfg,
    output logic      o_pend,
    output logic      o_wave,
    output logic      o_tick
);

    chan_cfg_t        r_act, r_shd;
    logic             r_pend;
    logic [WIDTH-1:0] r_cnt;
    logic             r_wave, r_tick;

    chan_cfg_t        w_act_d, w_shd_d;
    logic             w_pend_d;
    logic [WIDTH-1:0] w_cnt_d;
    logic             w_run, w_wrap, w_run_d, w_wave_d, w_tick_d;

    assign w_run  = r_act.en && (r_act.period != '0);
    assign w_wrap = w_run && (MAX_WIDTH'(r_cnt) == r_act.period - MAX_WIDTH'(1));

    always_comb begin
        w_act_d  = r_act;
        w_shd_d  = r_shd;
        w_pend_d = r_pend;
        w_cnt_d  = r_cnt;
        if (w_run) begin
            w_cnt_d = w_wrap ? '0 : r_cnt + WIDTH'(1);
        end
        if (w_wrap && r_pend) begin
            w_act_d  = r_shd;
            w_pend_d = 1'b0;
        end
        // A write only arrives with pend clear, so it never collides with the transfer above.
        if (i_wr) begin
            if (!w_run) begin
                w_act_d = i_cfg;
                w_cnt_d = '0;
            end else begin
                w_shd_d  = i_cfg;
                w_pend_d = 1'b1;
            end
        end
        w_run_d  = w_act_d.en && (w_act_d.period != '0);
        w_wave_d = w_run_d && (MAX_WIDTH'(w_cnt_d) < w_act_d.high);
        w_tick_d = w_run_d && (MAX_WIDTH'(w_cnt_d) == w_act_d.period - MAX_WIDTH'(1));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_act  <= '0;
            r_shd  <= '0;
            r_pend <= 1'b0;
            r_cnt  <= '0;
            r_wave <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_act  <= w_act_d;
            r_shd  <= w_shd_d;
            r_pend <= w_pend_d;
            r_cnt  <= w_cnt_d;
            r_wave <= w_wave_d;
            r_tick <= w_tick_d;
        end
    end

    assign o_pend = r_pend;
    assign o_wave = r_wave;
    assign o_tick = r_tick;

endmodule

// File: rtl/square_wave_multi.sv
// Multi-channel programmable square/PWM generator with double-buffered per-channel config.
module square_wave_multi
    import square_wave_pkg::*;
#(
    parameter int unsigned CH    = 4,
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_cfg_valid,
    output logic                        o_cfg_ready,
    input  logic [ch_sel_width(CH)-1:0] i_cfg_ch,
    input  logic [WIDTH-1:0]            i_cfg_period,
    input  logic [WIDTH-1:0]            i_cfg_high,
    input  logic                        i_cfg_en,
    output logic [CH-1:0]               o_wave_out,
    output logic [CH-1:0]               o_tick
);

    localparam int unsigned CH_W = ch_sel_width(CH);

    chan_cfg_t     w_cfg;
    logic [CH-1:0] w_wr, w_pend;
    logic          w_ready;

    assign w_cfg.en     = i_cfg_en;
    assign w_cfg.period = MAX_WIDTH'(i_cfg_period);
    assign w_cfg.high   = MAX_WIDTH'(i_cfg_high);

    // Selects beyond CH match no channel, so they stay ready and are dropped.
    always_comb begin
        w_ready = 1'b1;
        for (int i = 0; i < int'(CH); i++) begin
            if (i_cfg_ch == CH_W'(i)) begin
                w_ready = !w_pend[i];
            end
        end
    end

    assign o_cfg_ready = w_ready;

    for (genvar g = 0; g < int'(CH); g++) begin : g_chan
        assign w_wr[g] = i_cfg_valid && w_ready && (i_cfg_ch == CH_W'(g));

        square_wave_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_wr    (w_wr[g]),
            .i_cfg   (w_cfg),
            .o_pend  (w_pend[g]),
            .o_wave  (o_wave_out[g]),
            .o_tick  (o_tick[g])
        );
    end

endmodule

// File: doc/square_wave_multi.md
# square_wave_multi

Multi-channel programmable square/PWM wave generator. It is the parametrised successor of the single-channel fixed-duty square-wave source in the signal-generation library. It adds per-channel period, high time and enable, loaded through a valid/ready configuration port. Updates are double-buffered so every channel changes only at a period boundary and never glitches. It feeds test stimulus and clock-enable style outputs to downstream blocks.

## Interface
- `CH`, 4: number of independent channels (1..16).
- `WIDTH`, 8: width of period/high-time fields and per-channel counter (2..16).
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cfg_valid`  in  1  configuration write request.
- `cfg_ready`  out  1  write accepted when `cfg_valid & cfg_ready` at a rising edge.
- `cfg_ch`  in  $clog2(CH) (min 1)  target channel; values ≥ CH are accepted and discarded.
- `cfg_period`  in  WIDTH  period P in cycles; P=0 treated as disable.
- `cfg_high`  in  WIDTH  high time H in cycles.
- `cfg_en`  in  1  channel enable.
- `wave_out`  out  CH  registered waveform, one bit per channel.
- `tick`  out  CH  registered one-cycle pulse on the last cycle of each period.

## Operation
- Per channel: active regs {en, P, H}, shadow regs {en, P, H}, `pend` flag, counter `cnt` (WIDTH bits).
- Channel running iff active en=1 and active P≠0. Running: `cnt` counts 0..P-1 and wraps to 0. `wave_out[i]` = (cnt < H), so H≥P gives constant 1 and H=0 gives constant 0. `tick[i]`=1 while cnt==P-1; with P=1 tick is constant 1.
- Not running: cnt=0, wave_out=0, tick=0.
- `cfg_ready` = !pend[cfg_ch]. This is combinational from `cfg_ch`. For cfg_ch ≥ CH it is 1.
- Accepted write to an idle (not running) channel: active regs load directly at that edge, cnt=0, pend stays 0.
- Accepted write to a running channel: shadow regs load and pend=1. At the edge where cnt wraps (cnt==P-1), shadow is copied to active, cnt=0 and pend=0.
- Disable (cfg_en=0 or cfg_period=0) on a running channel therefore finishes the current period before the output goes 0.
- Writing an identical config still waits for the boundary.
- A write is rejected (ready=0) while pend is set. On the boundary edge pend is still 1, so a same-cycle write is not accepted; it is accepted the next cycle.

## Timing
- Reset (rst_n=0 at an edge): all cnt, active and shadow regs, pend, wave_out and tick go to 0. cfg_ready=1 from the next cycle. Reset mid-period aborts immediately with no boundary wait.
- Idle-channel write accepted at edge k: after edge k, cnt=0, wave_out=(H>0), tick=(P==1). First tick at edge k+P-1.
- Running-channel write: new settings visible from the edge after the wrap. Worst case is P cycles after acceptance.
- Period of wave_out is exactly P cycles and high for min(H,P) cycles. Phase is not aligned between channels unless they are started by writes P-multiples apart.
- Throughput: one accepted write per cycle to distinct channels.

## Structure
- Package `square_wave_pkg`: `WIDTH` default, `chan_cfg_t` struct {en, period, high}, helper function for channel-select width.
- Sub-module `square_wave_chan` (one instance per channel via generate). It holds the active/shadow regs, pend, cnt, wave_out and tick, and takes a per-channel write strobe plus `chan_cfg_t`.
- Top: write decode, cfg_ready mux, output concatenation.

## Test plan
- Reset then idle: rst_n low 2 cycles, no writes. Expect wave_out=0, tick=0, cfg_ready=1 for 50 cycles.
- Basic PWM: ch0 P=8, H=3, en=1. Expect wave_out[0] pattern 3 high / 5 low repeating, tick[0] every 8th cycle, and no more than 3 consecutive ones.
- Extremes: ch1 P=5, H=0 gives constant 0. H=5 and H=9 give constant 1. P=0, en=1 gives idle. P=1, H=1 gives wave=1 and tick=1 every cycle.
- Glitch-free update: ch2 running P=10, H=5. Write P=4, H=2 at cnt=3. Expect cfg_ready=0 for ch2 until the wrap, old waveform through cnt=9, then 2/2 pattern. A write attempted on the wrap cycle is accepted one cycle later.
- Independent channels: all 4 channels with P=4,6,8,10 and H=P/2 written back-to-back. Expect each channel's period and duty correct, and writes to other channels accepted while ch0 is pending.
- Reset mid-operation: assert rst_n=0 at cnt=4 of a P=8 channel with a pending update. Expect all outputs 0 next cycle, pend cleared, and the pending config not applied after release.
